// File: rtl/axi_sram_rw_sched_if.sv
// AXI read/write channel bundle between one master and the SRAM scheduler.
// Valid/ready: a transfer happens in a cycle where both are high; a source holds its payload stable while valid waits.
interface axi_sram_rw_sched_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int ID_W   = 4
);
   logic [ADDR_W-1:0]   araddr;
   logic [ID_W-1:0]     arid;
   logic [3:0]          arlen;
   logic [1:0]          arburst;
   logic                arvalid;
   logic                arready;

   logic [DATA_W-1:0]   rdata;
   logic [ID_W-1:0]     rid;
   logic [1:0]          rresp;
   logic                rlast;
   logic                rvalid;
   logic                rready;

   logic [ADDR_W-1:0]   awaddr;
   logic [ID_W-1:0]     awid;
   logic [3:0]          awlen;
   logic [1:0]          awburst;
   logic                awvalid;
   logic                awready;

   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic                wlast;
   logic                wvalid;
   logic                wready;

   logic [ID_W-1:0]     bid;
   logic [1:0]          bresp;
   logic                bvalid;
   logic                bready;

   modport master (
      output araddr, arid, arlen, arburst, arvalid, input arready,
      input  rdata, rid, rresp, rlast, rvalid, output rready,
      output awaddr, awid, awlen, awburst, awvalid, input awready,
      output wdata, wstrb, wlast, wvalid, input wready,
      input  bid, bresp, bvalid, output bready
   );

   modport slave (
      input  araddr, arid, arlen, arburst, arvalid, output arready,
      output rdata, rid, rresp, rlast, rvalid, input rready,
      input  awaddr, awid, awlen, awburst, awvalid, output awready,
      input  wdata, wstrb, wlast, wvalid, output wready,
      output bid, bresp, bvalid, input bready
   );
endinterface

// File: rtl/axi_sram_rw_sched.sv
// Shares one single-ported 1-cycle SRAM between AXI reads and writes, one burst at a time,
// with round-robin arbitration between read and write requests.
module axi_sram_rw_sched #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int ID_W   = 4
) (
   input  logic                aclk,
   input  logic                aresetn,
   axi_sram_rw_sched_if.slave  m,
   output logic                ram_ren,
   output logic [ADDR_W-1:0]   ram_raddr,
   input  logic [DATA_W-1:0]   ram_rdata,
   output logic [DATA_W/8-1:0] ram_wen,
   output logic [ADDR_W-1:0]   ram_waddr,
   output logic [DATA_W-1:0]   ram_wdata,
   output logic [1:0]          dbg_state
);
   localparam int BYTES = DATA_W / 8;
   localparam int LSB   = $clog2(BYTES);
   localparam logic [ADDR_W-1:0] BEAT = ADDR_W'(BYTES);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RD    = 2'd1;
   localparam logic [1:0] S_WR    = 2'd2;
   localparam logic [1:0] S_WRESP = 2'd3;

   logic [1:0]        state_q;
   logic [ADDR_W-1:0] addr_q;
   logic [ID_W-1:0]   id_q;
   logic [3:0]        len_q;
   logic [1:0]        burst_q;
   logic [4:0]        cnt_q;
   logic [3:0]        rbeat_q;
   logic              out_q;
   logic              last_wr_q;
   logic [1:0]        bresp_q;

   logic              rd_grant;
   logic              wr_grant;
   logic              wrap_ok;
   logic [ADDR_W-1:0] wrap_mask;
   logic [ADDR_W-1:0] addr_inc;
   logic [ADDR_W-1:0] addr_nxt;
   logic              rd_issue;
   logic              rd_hs;
   logic              rd_last;
   logic              wr_beat;
   logic              in_len;

   // On a tie, the channel that did not win last time goes first.
   always_comb begin
      rd_grant = (state_q == S_IDLE) && m.arvalid && (!m.awvalid || last_wr_q);
      wr_grant = (state_q == S_IDLE) && m.awvalid && (!m.arvalid || !last_wr_q);
   end

   // WRAP keeps the bits above the (len+1)-beat window and lets the low bits roll over.
   always_comb begin
      wrap_ok   = (burst_q == 2'b10) &&
                  ((len_q == 4'd1) || (len_q == 4'd3) || (len_q == 4'd7) || (len_q == 4'd15));
      wrap_mask = (ADDR_W'(len_q) << LSB) | ADDR_W'(BYTES - 1);
      addr_inc  = addr_q + BEAT;
      if (burst_q == 2'b00)
         addr_nxt = addr_q;
      else if (wrap_ok)
         addr_nxt = (addr_q & ~wrap_mask) | (addr_inc & wrap_mask);
      else
         addr_nxt = addr_inc;
   end

   always_comb begin
      rd_issue = (state_q == S_RD) && ({1'b0, len_q} >= cnt_q) && (!out_q || m.rready);
      rd_hs    = out_q && m.rready;
      rd_last  = out_q && (rbeat_q == len_q);
      wr_beat  = (state_q == S_WR) && m.wvalid;
      in_len   = (cnt_q <= {1'b0, len_q});
   end

   // Outputs are gated to zero whenever they carry nothing, so reset forces them all low.
   always_comb begin
      m.arready = aresetn && rd_grant;
      m.awready = aresetn && wr_grant;
      m.rvalid  = out_q;
      m.rlast   = rd_last;
      m.rdata   = out_q ? ram_rdata : '0;
      m.rid     = out_q ? id_q : '0;
      m.rresp   = 2'b00;
      m.wready  = (state_q == S_WR);
      m.bvalid  = (state_q == S_WRESP);
      m.bid     = (state_q == S_WRESP) ? id_q : '0;
      m.bresp   = (state_q == S_WRESP) ? bresp_q : 2'b00;
      ram_ren   = rd_issue;
      ram_raddr = rd_issue ? addr_q : '0;
      ram_wen   = (wr_beat && in_len) ? m.wstrb : '0;
      ram_waddr = wr_beat ? addr_q : '0;
      ram_wdata = wr_beat ? m.wdata : '0;
      dbg_state = state_q;
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q   <= S_IDLE;
         addr_q    <= '0;
         id_q      <= '0;
         len_q     <= '0;
         burst_q   <= '0;
         cnt_q     <= '0;
         rbeat_q   <= '0;
         out_q     <= 1'b0;
         last_wr_q <= 1'b1;
         bresp_q   <= 2'b00;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (rd_grant) begin
                  addr_q    <= m.araddr;
                  id_q      <= m.arid;
                  len_q     <= m.arlen;
                  burst_q   <= m.arburst;
                  cnt_q     <= '0;
                  last_wr_q <= 1'b0;
                  state_q   <= S_RD;
               end else if (wr_grant) begin
                  addr_q    <= m.awaddr;
                  id_q      <= m.awid;
                  len_q     <= m.awlen;
                  burst_q   <= m.awburst;
                  cnt_q     <= '0;
                  last_wr_q <= 1'b1;
                  state_q   <= S_WR;
               end
            end
            S_RD: begin
               if (rd_issue) begin
                  out_q   <= 1'b1;
                  rbeat_q <= cnt_q[3:0];
                  cnt_q   <= cnt_q + 5'd1;
                  addr_q  <= addr_nxt;
               end else if (rd_hs) begin
                  out_q <= 1'b0;
               end
               if (rd_hs && rd_last) begin
                  out_q   <= 1'b0;
                  state_q <= S_IDLE;
               end
            end
            S_WR: begin
               if (wr_beat) begin
                  // Saturate so an over-long burst cannot wrap back into range.
                  if (cnt_q != 5'h1f) cnt_q <= cnt_q + 5'd1;
                  addr_q <= addr_nxt;
                  if (m.wlast) begin
                     bresp_q <= (cnt_q == {1'b0, len_q}) ? 2'b00 : 2'b10;
                     state_q <= S_WRESP;
                  end
               end
            end
            S_WRESP: begin
               if (m.bready) state_q <= S_IDLE;
            end
         endcase
      end
   end
endmodule
